// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller_pkg
//  Brief    : Shared encodings for the multi-cycle MIPS controller: FSM
//             states, instruction classes, opcode/func codes and datapath
//             select constants.
//  Revision : 1.0 - initial release
// ============================================================================
package mc_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_MDU_WAIT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_J, CLS_JAL, CLS_JR,
    CLS_MFHI, CLS_MFLO, CLS_MULT, CLS_DIV, CLS_ILLEGAL
  } cls_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function codes (IR[5:0]) for R-type
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  // Idle value for selects when no instruction is being decoded
  localparam logic [1:0] SEL2_SAFE = 2'b11;
  localparam logic [2:0] SEL3_SAFE = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] REGDATA_ALU  = 2'b00;
  localparam logic [1:0] REGDATA_MEM  = 2'b01;
  localparam logic [1:0] REGDATA_RA   = 2'b10;
  localparam logic [1:0] REGDATA_HILO = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] NPC_GENERAL = 2'b00;
  localparam logic [1:0] NPC_B       = 2'b01;
  localparam logic [1:0] NPC_J       = 2'b10;
  localparam logic [1:0] NPC_JR      = 2'b11;

  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_LEZ = 2'b01;

  localparam logic [2:0] LS_W = 3'b000;
  localparam logic [2:0] LS_H = 3'b001;
  localparam logic [2:0] LS_B = 3'b010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  localparam logic MDU_MULT = 1'b0;
  localparam logic MDU_DIV  = 1'b1;

  typedef struct packed {
    cls_t       cls;
    logic [1:0] reg_dst;
    logic [1:0] reg_data;
    logic [1:0] ext_op;
    logic [1:0] npc_sel;
    logic [1:0] cmp_sel;
    logic [2:0] ls_sel;
    logic [2:0] alu_op;
    logic       mdu_op;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_decode
//  Brief    : Combinational op/func decode into an instruction class plus the
//             static datapath selects for that instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_decode
  import mc_controller_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  // Anything not matched stays CLS_ILLEGAL with safe selects and sequential PC
  always_comb begin
    dec = '{cls: CLS_ILLEGAL, reg_dst: SEL2_SAFE, reg_data: SEL2_SAFE,
            ext_op: SEL2_SAFE, npc_sel: NPC_GENERAL, cmp_sel: SEL2_SAFE,
            ls_sel: SEL3_SAFE, alu_op: SEL3_SAFE, mdu_op: MDU_MULT};
    case (op)
      OP_RTYPE: begin
        case (func)
          F_ADDU, F_SUBU, F_AND, F_OR, F_SLT: begin
            dec.cls      = CLS_ALU;
            dec.reg_dst  = REGDST_RD;
            dec.reg_data = REGDATA_ALU;
            case (func)
              F_SUBU:  dec.alu_op = ALU_SUB;
              F_AND:   dec.alu_op = ALU_AND;
              F_OR:    dec.alu_op = ALU_OR;
              F_SLT:   dec.alu_op = ALU_SLT;
              default: dec.alu_op = ALU_ADD;
            endcase
          end
          F_JR: begin
            dec.cls     = CLS_JR;
            dec.npc_sel = NPC_JR;
          end
          F_MFHI, F_MFLO: begin
            dec.cls      = (func == F_MFHI) ? CLS_MFHI : CLS_MFLO;
            dec.reg_dst  = REGDST_RD;
            dec.reg_data = REGDATA_HILO;
          end
          F_MULT: begin
            dec.cls    = CLS_MULT;
            dec.mdu_op = MDU_MULT;
          end
          F_DIV: begin
            dec.cls    = CLS_DIV;
            dec.mdu_op = MDU_DIV;
          end
          default: ;
        endcase
      end
      OP_J: begin
        dec.cls     = CLS_J;
        dec.npc_sel = NPC_J;
      end
      OP_JAL: begin
        dec.cls      = CLS_JAL;
        dec.npc_sel  = NPC_J;
        dec.reg_dst  = REGDST_RA;
        dec.reg_data = REGDATA_RA;
      end
      OP_BEQ, OP_BLEZ: begin
        dec.cls     = CLS_BRANCH;
        dec.npc_sel = NPC_B;
        dec.ext_op  = EXT_SIGN;
        dec.alu_op  = ALU_SUB;
        dec.cmp_sel = (op == OP_BEQ) ? CMP_EQ : CMP_LEZ;
      end
      OP_ADDIU, OP_ORI, OP_LUI: begin
        dec.cls      = CLS_ALU;
        dec.reg_dst  = REGDST_RT;
        dec.reg_data = REGDATA_ALU;
        case (op)
          OP_ORI:  begin dec.ext_op = EXT_ZERO; dec.alu_op = ALU_OR;  end
          OP_LUI:  begin dec.ext_op = EXT_LUI;  dec.alu_op = ALU_LUI; end
          default: begin dec.ext_op = EXT_SIGN; dec.alu_op = ALU_ADD; end
        endcase
      end
      OP_LW, OP_LH, OP_LB: begin
        dec.cls      = CLS_LOAD;
        dec.reg_dst  = REGDST_RT;
        dec.reg_data = REGDATA_MEM;
        dec.ext_op   = EXT_SIGN;
        dec.alu_op   = ALU_ADD;
        dec.ls_sel   = (op == OP_LW) ? LS_W : ((op == OP_LH) ? LS_H : LS_B);
      end
      OP_SW, OP_SH, OP_SB: begin
        dec.cls    = CLS_STORE;
        dec.ext_op = EXT_SIGN;
        dec.alu_op = ALU_ADD;
        dec.ls_sel = (op == OP_SW) ? LS_W : ((op == OP_SH) ? LS_H : LS_B);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller
//  Brief    : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB plus
//             MDU_WAIT) with ready-handshaked memories and MDU wait counter.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       reg_wr,
  output logic       dm_rd,
  output logic       dm_wr,
  output logic       hilo_wr,
  output logic       mdu_start,
  output logic       mdu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] reg_data,
  output logic [1:0] ext_op,
  output logic [1:0] npc_sel,
  output logic [1:0] cmp_sel,
  output logic [2:0] ls_sel,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  dec_t             dec;
  state_t           cur;
  logic [CNT_W-1:0] cnt;
  logic             mdu_done;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .dec  (dec)
  );

  assign mdu_done = (cnt == '0);
  assign state    = cur;

  // State register and MDU wait counter; reset returns to FETCH with counter cleared
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur <= S_FETCH;
      cnt <= '0;
    end else begin
      case (cur)
        S_FETCH:  if (imem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (dec.cls)
            CLS_J, CLS_JAL, CLS_JR, CLS_MFHI, CLS_MFLO, CLS_ILLEGAL: cur <= S_FETCH;
            default: cur <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (dec.cls)
            CLS_BRANCH:          cur <= S_FETCH;
            CLS_LOAD, CLS_STORE: cur <= S_MEM;
            CLS_MULT: begin
              cnt <= CNT_W'(MULT_CYCLES - 1);
              cur <= S_MDU_WAIT;
            end
            CLS_DIV: begin
              cnt <= CNT_W'(DIV_CYCLES - 1);
              cur <= S_MDU_WAIT;
            end
            default: cur <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) cur <= (dec.cls == CLS_LOAD) ? S_WB : S_FETCH;
        end
        S_WB: cur <= S_FETCH;
        S_MDU_WAIT: begin
          if (mdu_done) cur <= S_FETCH;
          else          cnt <= cnt - CNT_W'(1);
        end
        default: cur <= S_FETCH;
      endcase
    end
  end

  // Output decode from state and the instruction held in IR; everything is
  // forced idle while reset is asserted so no write can escape that cycle
  always_comb begin
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    reg_wr    = 1'b0;
    dm_rd     = 1'b0;
    dm_wr     = 1'b0;
    hilo_wr   = 1'b0;
    mdu_start = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    mdu_op    = 1'b0;
    reg_dst   = SEL2_SAFE;
    reg_data  = SEL2_SAFE;
    ext_op    = SEL2_SAFE;
    npc_sel   = SEL2_SAFE;
    cmp_sel   = SEL2_SAFE;
    ls_sel    = SEL3_SAFE;
    alu_op    = SEL3_SAFE;
    if (reset && (cur != S_FETCH)) begin
      reg_dst  = dec.reg_dst;
      reg_data = dec.reg_data;
      ext_op   = dec.ext_op;
      npc_sel  = dec.npc_sel;
      cmp_sel  = dec.cmp_sel;
      ls_sel   = dec.ls_sel;
      alu_op   = dec.alu_op;
      mdu_op   = dec.mdu_op;
    end
    if (reset) begin
      case (cur)
        S_FETCH: ir_wr = imem_ready;
        S_DECODE: begin
          case (dec.cls)
            CLS_J, CLS_JR: begin
              pc_wr  = 1'b1;
              retire = 1'b1;
            end
            CLS_JAL, CLS_MFHI, CLS_MFLO: begin
              reg_wr = 1'b1;
              pc_wr  = 1'b1;
              retire = 1'b1;
            end
            CLS_ILLEGAL: begin
              pc_wr   = 1'b1;
              retire  = 1'b1;
              illegal = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          case (dec.cls)
            CLS_BRANCH: begin
              pc_wr  = 1'b1;
              retire = 1'b1;
            end
            CLS_MULT, CLS_DIV: mdu_start = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          if (dec.cls == CLS_LOAD) begin
            dm_rd = 1'b1;
          end else begin
            dm_wr  = 1'b1;
            pc_wr  = dmem_ready;
            retire = dmem_ready;
          end
        end
        S_WB: begin
          reg_wr = 1'b1;
          pc_wr  = 1'b1;
          retire = 1'b1;
        end
        S_MDU_WAIT: begin
          hilo_wr = mdu_done;
          pc_wr   = mdu_done;
          retire  = mdu_done;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_controller
//  Brief    : Table-driven self-checking bench for mc_controller plus
//             hand-written reset, fetch-stall and short-MDU sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset, reset1;
  logic [5:0] op, func;
  logic       imem_ready, dmem_ready;
  logic       ir_wr, pc_wr, reg_wr, dm_rd, dm_wr, hilo_wr, mdu_start, mdu_op;
  logic [1:0] reg_dst, reg_data, ext_op, npc_sel, cmp_sel;
  logic [2:0] ls_sel, alu_op, state;
  logic       retire, illegal;
  logic       ir_wr_1, pc_wr_1, reg_wr_1, dm_rd_1, dm_wr_1, hilo_wr_1, mdu_start_1, mdu_op_1;
  logic [1:0] reg_dst_1, reg_data_1, ext_op_1, npc_sel_1, cmp_sel_1;
  logic [2:0] ls_sel_1, alu_op_1, state_1;
  logic       retire_1, illegal_1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mc_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .reg_wr(reg_wr), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .hilo_wr(hilo_wr), .mdu_start(mdu_start), .mdu_op(mdu_op),
    .reg_dst(reg_dst), .reg_data(reg_data), .ext_op(ext_op), .npc_sel(npc_sel),
    .cmp_sel(cmp_sel), .ls_sel(ls_sel), .alu_op(alu_op),
    .retire(retire), .illegal(illegal), .state(state)
  );

  // Second instance with single-cycle MDU latency
  mc_controller #(.MULT_CYCLES(1), .DIV_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset1), .op(op), .func(func),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir_wr(ir_wr_1), .pc_wr(pc_wr_1), .reg_wr(reg_wr_1), .dm_rd(dm_rd_1), .dm_wr(dm_wr_1),
    .hilo_wr(hilo_wr_1), .mdu_start(mdu_start_1), .mdu_op(mdu_op_1),
    .reg_dst(reg_dst_1), .reg_data(reg_data_1), .ext_op(ext_op_1), .npc_sel(npc_sel_1),
    .cmp_sel(cmp_sel_1), .ls_sel(ls_sel_1), .alu_op(alu_op_1),
    .retire(retire_1), .illegal(illegal_1), .state(state_1)
  );

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    int         stall;
    int         lat;
    logic [63:0] trace;
    int         nreg, nrd, nwr, nmdu, nill;
    logic [1:0] npc, dst, rdata;
    logic       mduop;
  } vec_t;

  // Observations from one instruction run
  int          r_lat, r_nir, r_npc, r_nreg, r_nrd, r_nwr, r_nmdu, r_nhilo, r_nill;
  logic [63:0] r_trace;
  logic [1:0]  r_npcsel, r_dst, r_rdata;
  logic        r_mduop, r_hilo_ret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Runs one instruction from its FETCH cycle until retire (bounded)
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int stall);
    int mem_cycles = 0;
    bit done = 1'b0;
    r_lat = 0; r_nir = 0; r_npc = 0; r_nreg = 0; r_nrd = 0; r_nwr = 0;
    r_nmdu = 0; r_nhilo = 0; r_nill = 0; r_trace = '0;
    r_npcsel = 2'b00; r_dst = 2'b00; r_rdata = 2'b00; r_mduop = 1'b0; r_hilo_ret = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin op = o; func = f; end
      if (state == 3'd3) mem_cycles++;
      imem_ready = (state == 3'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      dmem_ready = (state == 3'd3) ? (mem_cycles > stall) : 1'($urandom_range(0, 1));
      #1;
      r_trace = (r_trace << 3) | 64'(state);
      r_nir   += int'(ir_wr);
      r_npc   += int'(pc_wr);
      r_nreg  += int'(reg_wr);
      r_nrd   += int'(dm_rd);
      r_nwr   += int'(dm_wr);
      r_nmdu  += int'(mdu_start);
      r_nhilo += int'(hilo_wr);
      r_nill  += int'(illegal);
      check("inv_pc_eq_retire", 64'(pc_wr), 64'(retire));
      check("inv_ir_only_fetch", 64'(ir_wr && (state != 3'd0)), 64'd0);
      check("inv_dmwr_regwr", 64'(dm_wr & reg_wr), 64'd0);
      if (mdu_start) r_mduop = mdu_op;
      if (retire) begin
        r_lat = c; r_npcsel = npc_sel; r_dst = reg_dst; r_rdata = reg_data;
        r_hilo_ret = hilo_wr; done = 1'b1;
      end
    end
    check("retire_seen", 64'(done), 64'd1);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"addu",   6'h00, 6'h21, 0, 4,  64'o124,          1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1'b0});
    vecs.push_back('{"lw",     6'h23, 6'h00, 3, 8,  64'o1233334,      1, 4, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1'b0});
    vecs.push_back('{"sw",     6'h2B, 6'h00, 0, 4,  64'o123,          0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 1'b0});
    vecs.push_back('{"beq",    6'h04, 6'h00, 0, 3,  64'o12,           0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1'b0});
    vecs.push_back('{"mult",   6'h00, 6'h18, 0, 8,  64'o1255555,      0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1'b0});
    vecs.push_back('{"div",    6'h00, 6'h1A, 0, 13, 64'o125555555555, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1'b1});
    vecs.push_back('{"jal",    6'h03, 6'h00, 0, 2,  64'o1,            1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b10, 1'b0});
    vecs.push_back('{"ill_op", 6'h3F, 6'h00, 0, 2,  64'o1,            0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1'b0});
    vecs.push_back('{"jr",     6'h00, 6'h08, 0, 2,  64'o1,            0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1'b0});
    vecs.push_back('{"mfhi",   6'h00, 6'h10, 0, 2,  64'o1,            1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b11, 1'b0});
    vecs.push_back('{"mflo",   6'h00, 6'h12, 0, 2,  64'o1,            1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b11, 1'b0});
    vecs.push_back('{"sw_stl", 6'h2B, 6'h00, 2, 6,  64'o12333,        0, 0, 3, 0, 0, 2'b00, 2'b00, 2'b00, 1'b0});
    vecs.push_back('{"lb",     6'h20, 6'h00, 0, 5,  64'o1234,         1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1'b0});
    vecs.push_back('{"ori",    6'h0D, 6'h00, 0, 4,  64'o124,          1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1'b0});
    vecs.push_back('{"ill_fn", 6'h00, 6'h3F, 0, 2,  64'o1,            0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1'b0});
    vecs.push_back('{"blez",   6'h06, 6'h00, 0, 3,  64'o12,           0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1'b0});

    // Reset state
    reset = 1'b0; reset1 = 1'b0; op = 6'h00; func = 6'h21;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 64'(state), 64'd0);
    check("reset_enables", 64'({ir_wr, pc_wr, reg_wr, dm_rd, dm_wr, hilo_wr, mdu_start, retire, illegal}), 64'd0);
    check("reset_selects", 64'({reg_dst, reg_data, ext_op, npc_sel, cmp_sel, ls_sel, alu_op}), 64'hFFFF);
    imem_ready = 1'b0;
    reset = 1'b1;

    // Table-driven instructions
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].func, vecs[i].stall);
      check({vecs[i].name, "_lat"},   64'(r_lat),   64'(vecs[i].lat));
      check({vecs[i].name, "_trace"}, r_trace,      vecs[i].trace);
      check({vecs[i].name, "_ir"},    64'(r_nir),   64'd1);
      check({vecs[i].name, "_pcwr"},  64'(r_npc),   64'd1);
      check({vecs[i].name, "_regwr"}, 64'(r_nreg),  64'(vecs[i].nreg));
      check({vecs[i].name, "_dmrd"},  64'(r_nrd),   64'(vecs[i].nrd));
      check({vecs[i].name, "_dmwr"},  64'(r_nwr),   64'(vecs[i].nwr));
      check({vecs[i].name, "_mdu"},   64'(r_nmdu),  64'(vecs[i].nmdu));
      check({vecs[i].name, "_hilo"},  64'(r_nhilo), 64'(vecs[i].nmdu));
      check({vecs[i].name, "_hilo_at_retire"}, 64'(r_hilo_ret), 64'(vecs[i].nmdu));
      check({vecs[i].name, "_illegal"}, 64'(r_nill), 64'(vecs[i].nill));
      check({vecs[i].name, "_npc"},   64'(r_npcsel), 64'(vecs[i].npc));
      if (vecs[i].nreg > 0) begin
        check({vecs[i].name, "_regdst"},  64'(r_dst),   64'(vecs[i].dst));
        check({vecs[i].name, "_regdata"}, 64'(r_rdata), 64'(vecs[i].rdata));
      end
      if (vecs[i].nmdu > 0) check({vecs[i].name, "_mduop"}, 64'(r_mduop), 64'(vecs[i].mduop));
    end

    // Reset asserted in MDU_WAIT with counter at 3 (second wait cycle of mult)
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin op = 6'h00; func = 6'h18; end
      imem_ready = (c == 1);
      dmem_ready = 1'b1;
      #1;
    end
    check("rstmdu_pre_state", 64'(state), 64'd5);
    check("rstmdu_pre_retire", 64'(retire), 64'd0);
    reset = 1'b0;
    #1;
    check("rstmdu_gate", 64'({hilo_wr, retire, pc_wr}), 64'd0);
    @(negedge clk);
    imem_ready = 1'b1;
    #1;
    check("rstmdu_state", 64'(state), 64'd0);
    check("rstmdu_enables", 64'({hilo_wr, retire, pc_wr, ir_wr, reg_wr}), 64'd0);
    imem_ready = 1'b0;
    reset = 1'b1;
    run_instr(6'h00, 6'h18, 0);
    check("mult_after_rst_lat", 64'(r_lat), 64'd8);
    check("mult_after_rst_hilo", 64'(r_nhilo), 64'd1);

    // Instruction memory not ready for four cycles
    begin
      int  c = 0;
      bit  got = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k == 1) begin op = 6'h00; func = 6'h21; end
        imem_ready = 1'b0; dmem_ready = 1'b1;
        #1;
        check("imem_wait", 64'({state, ir_wr}), 64'd0);
      end
      @(negedge clk);
      imem_ready = 1'b1;
      #1;
      check("imem_ready_irwr", 64'(ir_wr), 64'd1);
      c = 5;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        imem_ready = 1'b0;
        c++;
        #1;
        if (retire) got = 1'b1;
      end
      check("imem_stall_lat", got ? 64'(c) : 64'd0, 64'd8);
    end

    // Single-cycle MDU latency on the second instance
    @(negedge clk);
    reset = 1'b0; reset1 = 1'b1; imem_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      int  c = 0;
      bit  got = 1'b0;
      int  start_cyc = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
        @(negedge clk);
        if (k == 1) begin op = 6'h00; func = (t == 0) ? 6'h1A : 6'h18; end
        imem_ready = (k == 1); dmem_ready = 1'b1;
        c = k;
        #1;
        if (mdu_start_1) start_cyc = k;
        if (retire_1) begin
          got = 1'b1;
          check("mdu1_state_at_retire", 64'(state_1), 64'd5);
          check("mdu1_hilo_at_retire", 64'(hilo_wr_1), 64'd1);
        end
      end
      check((t == 0) ? "div1_lat" : "mult1_lat", got ? 64'(c) : 64'd0, 64'd4);
      check((t == 0) ? "div1_start" : "mult1_start", 64'(start_cyc), 64'd3);
    end
    reset1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
